inverse_search_engine: RTL and testbench

- Sequential inverse of the team's 6-bit-in / 24-bit-out combinational transform blocks: given a 24-bit target output, it finds which input code(s) produce it.
- Drives candidate codes into an external instance of the forward function (fn_in), reads its result (fn_out) and compares against the target.
- Reports the lowest matching input and the number of matching inputs over a valid/ready response channel.

---
 rtl/inverse_search_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_inverse_search_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_search_engine.sv
// -----------------------------------------------------------------------------
// inverse_search_engine
//
// Sequential inverse of a small forward transform. Given a target output
// value, the engine sweeps every input code through an external instance of
// the forward function, compares each result against the target and reports
// the lowest matching code together with the number of matching codes.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   search request valid
//   req_ready   engine can accept a request (only in IDLE, out of reset)
//   req_target  target output value, captured on the request handshake
//   fn_in       candidate code driven to the forward function
//   fn_out      forward function result, EVAL_LAT cycles after fn_in
//   rsp_valid   response valid (held until rsp_ready)
//   rsp_ready   response consumer ready
//   rsp_found   at least one code matched
//   rsp_data    lowest matching code, 0 when nothing matched
//   rsp_count   number of matching codes (0 .. 2^IN_W)
//
// Parameters:
//   IN_W      forward function input width; search space is 2^IN_W codes
//   OUT_W     forward function output / target width
//   EVAL_LAT  fixed latency of the external function (0 = combinational)
//
// Build option:
//   INVERSE_SEARCH_EARLY_EXIT_EN  when defined, the first match ends the
//                                 search; rsp_count is then 1 or 0.
// -----------------------------------------------------------------------------
module inverse_search_engine #(
   parameter int IN_W     = 6,
   parameter int OUT_W    = 24,
   parameter int EVAL_LAT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OUT_W-1:0] req_target,
   output logic [IN_W-1:0]  fn_in,
   input  logic [OUT_W-1:0] fn_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_found,
   output logic [IN_W-1:0]  rsp_data,
   output logic [IN_W:0]    rsp_count
);

   localparam int DRAIN_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((EVAL_LAT > 0) ? (EVAL_LAT - 1) : 0);
   localparam logic [IN_W-1:0]    CAND_LAST  = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [IN_W-1:0]     cand;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic [OUT_W-1:0]    target_p0;
   logic [IN_W-1:0]     first_code;
   logic [IN_W:0]       match_cnt;

   logic                issue;
   logic                accept;
   logic                tag_vld;
   logic [IN_W-1:0]     tag_code;
   logic                hit;
   logic                flush;

   // A candidate is presented on fn_in in every SWEEP cycle.
   assign issue  = (state == SWEEP);
   assign accept = req_valid && req_ready;

   // -------------------------------------------------------------------------
   // Tag pipeline: carries {valid, code} alongside the external evaluation so
   // that each fn_out is paired with the candidate that produced it.
   // -------------------------------------------------------------------------
   generate
      if (EVAL_LAT == 0) begin : g_tag_comb
         assign tag_vld  = issue;
         assign tag_code = cand;
      end else begin : g_tag_pipe
         logic [EVAL_LAT-1:0] vld_p;
         logic [IN_W-1:0]     code_p [EVAL_LAT];

         // A flush (early exit) drops every in-flight tag.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_p <= '0;
            end else begin
               vld_p[0] <= issue && !flush;
               for (int i = 1; i < EVAL_LAT; i++) begin
                  vld_p[i] <= vld_p[i-1] && !flush;
               end
            end
         end

         always_ff @(posedge clk) begin
            code_p[0] <= cand;
            for (int i = 1; i < EVAL_LAT; i++) begin
               code_p[i] <= code_p[i-1];
            end
         end

         assign tag_vld  = vld_p[EVAL_LAT-1];
         assign tag_code = code_p[EVAL_LAT-1];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Compare stage: full-width unsigned equality against the captured target.
   // -------------------------------------------------------------------------
   assign hit = tag_vld && (fn_out == target_p0) && ((state == SWEEP) || (state == DRAIN));

`ifdef INVERSE_SEARCH_EARLY_EXIT_EN
   assign flush = hit;
`else
   assign flush = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next state and handshake / candidate outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      fn_in     = '0;

      case (state)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid && rst_n) begin
               state_nxt = SWEEP;
            end
         end

         SWEEP: begin
            fn_in = cand;
            if (flush) begin
               // Remaining tags are discarded, so there is nothing to drain.
               state_nxt = RESP;
            end else if (cand == CAND_LAST) begin
               state_nxt = (EVAL_LAT > 0) ? DRAIN : RESP;
            end
         end

         DRAIN: begin
            // cand stops at the last code, so fn_in holds it while draining.
            fn_in = cand;
            if (flush || (drain_cnt == DRAIN_LAST)) begin
               state_nxt = RESP;
            end
         end

         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Candidate counter, drain counter and match accumulation
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand       <= '0;
         drain_cnt  <= '0;
         first_code <= '0;
         match_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cand       <= '0;
                  first_code <= '0;
                  match_cnt  <= '0;
               end
            end
            SWEEP: begin
               drain_cnt <= '0;
               if (cand != CAND_LAST) begin
                  cand <= cand + 1'b1;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
            end
            default: begin
            end
         endcase

         // Codes arrive in ascending order, so the first hit is the lowest.
         // The count is IN_W+1 bits wide and cannot wrap.
         if (hit) begin
            if (match_cnt == '0) begin
               first_code <= tag_code;
            end
            match_cnt <= match_cnt + 1'b1;
         end
      end
   end

   // Target is only meaningful while a search is in progress.
   always_ff @(posedge clk) begin
      if (accept) begin
         target_p0 <= req_target;
      end
   end

   assign rsp_found = (match_cnt != '0);
   assign rsp_data  = first_code;
   assign rsp_count = match_cnt;

endmodule

// File: tb/tb_inverse_search_engine.sv
// -----------------------------------------------------------------------------
// tb_inverse_search_engine
//
// Two engines share one stimulus path: instance a uses a combinational
// forward function (3*x or x&3, selected by fmode); instance b uses a
// two-stage registered x ^ 0x2A with EVAL_LAT = 2. Expected results come from
// an exhaustive bench-side model and pass through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_inverse_search_engine;

   typedef struct {
      logic       found;
      logic [5:0] data;
      logic [6:0] count;
      int         lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [23:0] req_target;
   logic        rsp_ready;
   int          sel;
   int          fmode;

   logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_found_a;
   logic [5:0]  fn_in_a, rsp_data_a;
   logic [23:0] fn_out_a;
   logic [6:0]  rsp_count_a;

   logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_found_b;
   logic [5:0]  fn_in_b, rsp_data_b;
   logic [23:0] fn_out_b, fn_r1, fn_r2;
   logic [6:0]  rsp_count_b;

   logic        rdy, rv, found;
   logic [5:0]  fin, data;
   logic [6:0]  count;

   int          checks;
   int          errors;
   exp_t        exp_q[$];

   function automatic logic [23:0] fwd(input int s, input int fm, input logic [5:0] x);
      if (s == 1) return {18'd0, x ^ 6'h2A};
      if (fm == 1) return {22'd0, x[1:0]};
      return 24'(x) * 24'd3;
   endfunction

   inverse_search_engine #(.IN_W(6), .OUT_W(24), .EVAL_LAT(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_target(req_target),
      .fn_in(fn_in_a), .fn_out(fn_out_a),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
      .rsp_found(rsp_found_a), .rsp_data(rsp_data_a), .rsp_count(rsp_count_a)
   );

   inverse_search_engine #(.IN_W(6), .OUT_W(24), .EVAL_LAT(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_target(req_target),
      .fn_in(fn_in_b), .fn_out(fn_out_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
      .rsp_found(rsp_found_b), .rsp_data(rsp_data_b), .rsp_count(rsp_count_b)
   );

   assign req_valid_a = req_valid && (sel == 0);
   assign rsp_ready_a = rsp_ready && (sel == 0);
   assign req_valid_b = req_valid && (sel == 1);
   assign rsp_ready_b = rsp_ready && (sel == 1);

   always_comb fn_out_a = fwd(0, fmode, fn_in_a);

   always_ff @(posedge clk) begin
      fn_r1 <= fwd(1, 0, fn_in_b);
      fn_r2 <= fn_r1;
   end
   assign fn_out_b = fn_r2;

   assign rdy   = (sel == 1) ? req_ready_b : req_ready_a;
   assign rv    = (sel == 1) ? rsp_valid_b : rsp_valid_a;
   assign found = (sel == 1) ? rsp_found_b : rsp_found_a;
   assign fin   = (sel == 1) ? fn_in_b     : fn_in_a;
   assign data  = (sel == 1) ? rsp_data_b  : rsp_data_a;
   assign count = (sel == 1) ? rsp_count_b : rsp_count_a;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge, model the expected response, push it and
   // return at the first negedge after the accepting edge.
   task automatic issue(input int s, input int fm, input logic [23:0] tgt);
      exp_t e;
      int   n;
      int   el;
      e.found = 1'b0;
      e.data  = '0;
      e.count = '0;
      for (int x = 0; x < 64; x++) begin
         if (fwd(s, fm, 6'(x)) == tgt) begin
            if (!e.found) e.data = 6'(x);
            e.found = 1'b1;
            e.count = e.count + 7'd1;
         end
      end
      el = (s == 1) ? 2 : 0;
`ifdef INVERSE_SEARCH_EARLY_EXIT_EN
      if (e.found) begin
         e.count = 7'd1;
         e.lat   = int'(e.data) + 1 + el + 1;
      end else begin
         e.lat = 64 + el + 1;
      end
`else
      e.lat = 64 + el + 1;
`endif
      sel        = s;
      fmode      = fm;
      req_target = tgt;
      req_valid  = 1'b1;
      n = 0;
      while (rdy !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_before_accept", 32'(rdy), 32'd1);
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
      req_valid  = 1'b0;
      req_target = ~tgt;
   endtask

   // Wait for the response (counting latency from the accept edge), compare
   // against the scoreboard, optionally hold backpressure, then complete it.
   task automatic collect(input bit hold);
      exp_t e;
      int   lat;
      lat = 1;
      while (rv !== 1'b1 && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_valid_seen", 32'(rv), 32'd1);
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("rsp_found", 32'(found), 32'(e.found));
         check("rsp_data", 32'(data), 32'(e.data));
         check("rsp_count", 32'(count), 32'(e.count));
         check("latency", 32'(lat), 32'(e.lat));
         if (hold) begin
            for (int i = 0; i < 20; i++) begin
               req_valid  = 1'b1;
               req_target = 24'($urandom);
               @(negedge clk);
               check("bp_rsp_valid", 32'(rv), 32'd1);
               check("bp_req_ready", 32'(rdy), 32'd0);
               check("bp_rsp_data", 32'(data), 32'(e.data));
               check("bp_rsp_count", 32'(count), 32'(e.count));
               check("bp_rsp_found", 32'(found), 32'(e.found));
            end
            rsp_ready = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("rsp_valid_dropped", 32'(rv), 32'd0);
      check("req_ready_after_rsp", 32'(rdy), 32'd1);
      req_valid = 1'b0;
   endtask

   initial begin
      int n;
      int seen;
      checks     = 0;
      errors     = 0;
      sel        = 0;
      fmode      = 0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_target = '0;
      rsp_ready  = 1'b1;

      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(rdy), 32'd0);
      check("reset_rsp_valid", 32'(rv), 32'd0);
      check("reset_fn_in", 32'(fin), 32'd0);
      check("reset_rsp_found", 32'(found), 32'd0);
      check("reset_rsp_data", 32'(data), 32'd0);
      check("reset_rsp_count", 32'(count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_req_ready", 32'(rdy), 32'd1);
      check("idle_fn_in", 32'(fin), 32'd0);

      // f(x) = 3x
      issue(0, 0, 24'h00002D); collect(1'b0);
      issue(0, 0, 24'h0000FF); collect(1'b0);
      issue(0, 0, 24'h10002D); collect(1'b0);
      issue(0, 0, 24'h000000); collect(1'b0);
      issue(0, 0, 24'h0000BD); collect(1'b0);
      // f(x) = x & 3
      issue(0, 1, 24'h000001); collect(1'b0);
      issue(0, 1, 24'h000003); collect(1'b0);
      // EVAL_LAT = 2, f(x) = x ^ 0x2A
      issue(1, 0, 24'h000000); collect(1'b0);
      issue(1, 0, 24'h00003F); collect(1'b0);
      issue(1, 0, 24'h000040); collect(1'b0);

      // Backpressure with a competing request held high
      rsp_ready = 1'b0;
      issue(0, 0, 24'h00002D);
      rsp_ready = 1'b0;
      collect(1'b1);

      // Reset while candidate 30 is on fn_in
      issue(0, 0, 24'h00002D);
      n = 0;
      while (fin !== 6'd30 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached_cand_30", 32'(fin), 32'd30);
      #1 rst_n = 1'b0;
      #1;
      check("abort_fn_in", 32'(fin), 32'd0);
      check("abort_rsp_valid", 32'(rv), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rv === 1'b1) seen++;
      end
      check("no_rsp_after_abort", 32'(seen), 32'd0);
      issue(0, 0, 24'h00002D); collect(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
